// File: rtl/xsw_pkg.sv
// Shared types and helpers for the xsw_nm_buf crossbar.
// The lock-state enum is used only when XSW_LOCK_EN is defined.
package xsw_pkg;

    // Widest source count rr_pick can arbitrate over.
    localparam int unsigned RR_MAX = 32;

    typedef enum logic [0:0] {
        LkFree,
        LkLocked
    } lock_st_e;

    // Bits needed to hold an occupancy count from 0 to depth inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // One-hot winner: the first set bit of req at or after ptr, wrapping within n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] req,
        input int unsigned       ptr,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] gnt;
        logic              found;
        int unsigned       idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/xsw_ofifo.sv
// Per-output FIFO: DEPTH entries, any DEPTH >= 1.
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module xsw_ofifo
    import xsw_pkg::*;
#(
    parameter int unsigned P     = 10,
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_push,
    input  logic [P-1:0]              i_pld,
    input  logic                      i_pop,
    output logic                      o_vld,
    output logic [P-1:0]              o_pld,
    output logic [lvl_w(DEPTH)-1:0]   o_lvl
);

    localparam int unsigned LW = lvl_w(DEPTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [P-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_lvl;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    // Qualify push/pop against occupancy and compute wrapped pointers.
    always_comb begin
        w_push     = i_push && (r_lvl != LW'(DEPTH));
        w_pop      = i_pop && (r_lvl != '0);
        w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
        w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
    end

    // Storage array; contents are never visible while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_pld;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_lvl  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + 1'b1;
                2'b01:   r_lvl <= r_lvl - 1'b1;
                default: r_lvl <= r_lvl;
            endcase
        end
    end

    // Head payload is masked to zero when empty.
    always_comb begin
        o_vld = (r_lvl != '0);
        o_pld = o_vld ? r_mem[r_rptr] : '0;
        o_lvl = r_lvl;
    end

endmodule

// File: rtl/xsw_nm_buf.sv
// N x M buffered crossbar: LUT routing on DST_ID, round-robin arbitration per
// output, DEPTH-entry FIFO per output. Unmapped beats are accepted, dropped and
// reported on err_s one cycle later.
// Optional feature: define XSW_LOCK_EN for per-output occupy/release locking.
module xsw_nm_buf
    import xsw_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned M     = 3,
    parameter int unsigned P     = 10,
    parameter int unsigned LU_N  = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [(2**LU_N)*M-1:0]        lut,
    input  logic [N-1:0]                  vld_s,
    input  logic [N*P-1:0]                pld_s,
    output logic [N-1:0]                  gnt_s,
    input  logic [N-1:0]                  ocy,
    input  logic [N-1:0]                  rel,
    output logic [M-1:0]                  vld_m,
    output logic [M*P-1:0]                pld_m,
    input  logic [M-1:0]                  gnt_m,
    output logic [N-1:0]                  err_s,
    output logic [M*lvl_w(DEPTH)-1:0]     lvl_m
);

    localparam int unsigned LW   = lvl_w(DEPTH);
    localparam int unsigned PTRW = (N > 1) ? $clog2(N) : 1;

    logic [LU_N-1:0]   w_dst      [N];
    logic [M-1:0]      w_tgt      [N];
    logic [N-1:0]      w_unmap;
    logic [N-1:0]      w_lock_ok  [M];
    logic [RR_MAX-1:0] w_req      [M];
    logic [RR_MAX-1:0] w_pick     [M];
    logic [N-1:0]      w_win      [M];
    logic [M-1:0]      w_room;
    logic [M-1:0]      w_push;
    logic [P-1:0]      w_push_pld [M];
    logic [M-1:0]      w_vld;
    logic [P-1:0]      w_pld      [M];
    logic [LW-1:0]     w_lvl      [M];

    logic [PTRW-1:0]   r_ptr      [M];
    logic [N-1:0]      r_err;

    // Route lookup: DST_ID of each lane selects a one-hot target row.
    always_comb begin
        w_unmap = '0;
        for (int i = 0; i < N; i++) begin
            w_dst[i]   = pld_s[i*P + P - 1 -: LU_N];
            w_tgt[i]   = lut[w_dst[i]*M +: M];
            w_unmap[i] = (w_tgt[i] == '0);
        end
    end

`ifdef XSW_LOCK_EN
    lock_st_e        r_lk_st      [M];
    logic [PTRW-1:0] r_lk_own     [M];
    lock_st_e        w_lk_st_nxt  [M];
    logic [PTRW-1:0] w_lk_own_nxt [M];

    // While locked, only the owner may request the output.
    always_comb begin
        for (int o = 0; o < M; o++) begin
            w_lock_ok[o] = '0;
            for (int i = 0; i < N; i++) begin
                w_lock_ok[o][i] = (r_lk_st[o] == LkFree) || (r_lk_own[o] == PTRW'(i));
            end
        end
    end

    // Lock next state: occupy without release locks, release by the owner frees.
    always_comb begin
        for (int o = 0; o < M; o++) begin
            w_lk_st_nxt[o]  = r_lk_st[o];
            w_lk_own_nxt[o] = r_lk_own[o];
            for (int i = 0; i < N; i++) begin
                if (w_win[o][i]) begin
                    if (r_lk_st[o] == LkFree && ocy[i] && !rel[i]) begin
                        w_lk_st_nxt[o]  = LkLocked;
                        w_lk_own_nxt[o] = PTRW'(i);
                    end else if (r_lk_st[o] == LkLocked && rel[i]) begin
                        w_lk_st_nxt[o] = LkFree;
                    end
                end
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int o = 0; o < M; o++) begin
                r_lk_st[o]  <= LkFree;
                r_lk_own[o] <= '0;
            end
        end else begin
            for (int o = 0; o < M; o++) begin
                r_lk_st[o]  <= w_lk_st_nxt[o];
                r_lk_own[o] <= w_lk_own_nxt[o];
            end
        end
    end
`else
    // No locking: every source may always request.
    always_comb begin
        for (int o = 0; o < M; o++) begin
            w_lock_ok[o] = '1;
        end
    end
`endif

    // Per-output request vector and room check.
    always_comb begin
        w_room = '0;
        for (int o = 0; o < M; o++) begin
            w_req[o]  = '0;
            w_room[o] = (w_lvl[o] < LW'(DEPTH));
            for (int i = 0; i < N; i++) begin
                w_req[o][i] = vld_s[i] & w_tgt[i][o] & w_lock_ok[o][i];
            end
        end
    end

    // Round-robin pick per output; a full FIFO grants nothing.
    always_comb begin
        for (int o = 0; o < M; o++) begin
            w_pick[o] = '0;
            if (rstn && w_room[o]) begin
                w_pick[o] = rr_pick(w_req[o], 32'(r_ptr[o]), N);
            end
            w_win[o] = w_pick[o][N-1:0];
        end
    end

    // Mux the winning payload into each FIFO.
    always_comb begin
        w_push = '0;
        for (int o = 0; o < M; o++) begin
            w_push_pld[o] = '0;
            for (int i = 0; i < N; i++) begin
                if (w_win[o][i]) begin
                    w_push[o]     = 1'b1;
                    w_push_pld[o] = pld_s[i*P +: P];
                end
            end
        end
    end

    // Source grants: arbitration winners plus unmapped beats (sunk immediately).
    always_comb begin
        gnt_s = '0;
        for (int i = 0; i < N; i++) begin
            gnt_s[i] = rstn & vld_s[i] & w_unmap[i];
        end
        for (int o = 0; o < M; o++) begin
            for (int i = 0; i < N; i++) begin
                if (w_win[o][i]) begin
                    gnt_s[i] = 1'b1;
                end
            end
        end
    end

    // Arbitration pointers: move past the winner, hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int o = 0; o < M; o++) begin
                r_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < M; o++) begin
                for (int i = 0; i < N; i++) begin
                    if (w_win[o][i]) begin
                        r_ptr[o] <= (i == N - 1) ? '0 : PTRW'(i + 1);
                    end
                end
            end
        end
    end

    // Error pulse one cycle after an unmapped beat is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
        end else begin
            r_err <= vld_s & w_unmap;
        end
    end

    assign err_s = r_err;

    for (genvar go = 0; go < M; go++) begin : g_out
        xsw_ofifo #(
            .P     (P),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rstn   (rstn),
            .i_push (w_push[go]),
            .i_pld  (w_push_pld[go]),
            .i_pop  (gnt_m[go]),
            .o_vld  (w_vld[go]),
            .o_pld  (w_pld[go]),
            .o_lvl  (w_lvl[go])
        );

        assign vld_m[go]           = w_vld[go];
        assign pld_m[go*P +: P]    = w_pld[go];
        assign lvl_m[go*LW +: LW]  = w_lvl[go];
    end

    // A valid beat must target at most one output.
    for (genvar gi = 0; gi < N; gi++) begin : g_tgt_chk
        a_tgt_onehot: assert property (@(posedge clk) disable iff (!rstn)
            vld_s[gi] |-> $onehot0(w_tgt[gi]));
    end

endmodule

// File: tb/tb_xsw_nm_buf.sv
// Scoreboard bench for xsw_nm_buf: a queue-based reference model predicts grants,
// occupancy and error pulses; a separate monitor checks popped payloads.
module tb_xsw_nm_buf;

    localparam int N     = 2;
    localparam int M     = 3;
    localparam int P     = 10;
    localparam int LU_N  = 2;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int NE    = 1 << LU_N;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NE*M-1:0]    lut;
    logic [N-1:0]       vld_s;
    logic [N*P-1:0]     pld_s;
    logic [N-1:0]       gnt_s;
    logic [N-1:0]       ocy;
    logic [N-1:0]       rel;
    logic [M-1:0]       vld_m;
    logic [M*P-1:0]     pld_m;
    logic [M-1:0]       gnt_m;
    logic [N-1:0]       err_s;
    logic [M*LW-1:0]    lvl_m;

    xsw_nm_buf #(
        .N     (N),
        .M     (M),
        .P     (P),
        .LU_N  (LU_N),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .lut   (lut),
        .vld_s (vld_s),
        .pld_s (pld_s),
        .gnt_s (gnt_s),
        .ocy   (ocy),
        .rel   (rel),
        .vld_m (vld_m),
        .pld_m (pld_m),
        .gnt_m (gnt_m),
        .err_s (err_s),
        .lvl_m (lvl_m)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [P-1:0] sb_q [M][$];
    int           m_lvl [M];
    int           m_ptr [M];
    int           m_own [M];
    logic [N-1:0] m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] lane(input int i);
        return pld_s[i*P +: P];
    endfunction

    // Target mask of a payload, read straight from the table.
    function automatic int tgt_of(input logic [P-1:0] p);
        int d;
        int t;
        d = int'(p >> (P - LU_N));
        t = 0;
        for (int o = 0; o < M; o++) begin
            if (lut[d*M + o]) t = t | (1 << o);
        end
        return t;
    endfunction

    task automatic model_clear();
        for (int o = 0; o < M; o++) begin
            sb_q[o].delete();
            m_lvl[o] = 0;
            m_ptr[o] = 0;
            m_own[o] = -1;
        end
        m_err = '0;
    endtask

    task automatic drv(input logic [N-1:0] v, input logic [P-1:0] p0, input logic [P-1:0] p1,
                       input logic [N-1:0] oc, input logic [N-1:0] rl, input logic [M-1:0] gm);
        vld_s = v;
        pld_s = {p1, p0};
        ocy   = oc;
        rel   = rl;
        gnt_m = gm;
    endtask

    // One cycle: predict, compare, clock, update model. Called at a negedge.
    task automatic step();
        logic [N-1:0] eg;
        logic [N-1:0] unm;
        int           win [M];
        int           i;
        #1;
        eg  = '0;
        unm = '0;
        for (int s = 0; s < N; s++) begin
            if (vld_s[s] && tgt_of(lane(s)) == 0) begin
                eg[s]  = 1'b1;
                unm[s] = 1'b1;
            end
        end
        for (int o = 0; o < M; o++) begin
            win[o] = -1;
            if (m_lvl[o] < DEPTH) begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[o] + k) % N;
                    if (win[o] < 0 && vld_s[i] && ((tgt_of(lane(i)) >> o) & 1) == 1 &&
                        (m_own[o] < 0 || m_own[o] == i)) begin
                        win[o] = i;
                    end
                end
            end
            if (win[o] >= 0) eg[win[o]] = 1'b1;
        end
        chk("gnt_s", 64'(gnt_s), 64'(eg));
        chk("err_s", 64'(err_s), 64'(m_err));
        for (int o = 0; o < M; o++) begin
            chk("lvl_m", 64'(lvl_m[o*LW +: LW]), 64'(m_lvl[o]));
            chk("vld_m", 64'(vld_m[o]), 64'(m_lvl[o] != 0));
            if (m_lvl[o] == 0) chk("pld_m_masked", 64'(pld_m[o*P +: P]), 64'(0));
        end
        @(posedge clk);
        for (int o = 0; o < M; o++) begin
            if (m_lvl[o] > 0 && gnt_m[o]) m_lvl[o]--;
            if (win[o] >= 0) begin
                sb_q[o].push_back(lane(win[o]));
                m_lvl[o]++;
                m_ptr[o] = (win[o] + 1) % N;
`ifdef XSW_LOCK_EN
                if (m_own[o] < 0 && ocy[win[o]] && !rel[win[o]]) m_own[o] = win[o];
                else if (m_own[o] == win[o] && rel[win[o]]) m_own[o] = -1;
`endif
            end
        end
        m_err = unm;
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_gnt_s"}, 64'(gnt_s), 64'(0));
        chk({nm, "_vld_m"}, 64'(vld_m), 64'(0));
        chk({nm, "_lvl_m"}, 64'(lvl_m), 64'(0));
        chk({nm, "_pld_m"}, 64'(pld_m), 64'(0));
        chk({nm, "_err_s"}, 64'(err_s), 64'(0));
    endtask

    // Monitor: whenever the DUT presents a head that will be popped, check it.
    initial begin
        logic [P-1:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (rstn) begin
                for (int o = 0; o < M; o++) begin
                    if (vld_m[o] && gnt_m[o]) begin
                        if (sb_q[o].size() == 0) begin
                            chk("pop_unexpected", 64'(vld_m[o]), 64'(0));
                        end else begin
                            exp = sb_q[o].pop_front();
                            chk("pld_m", 64'(pld_m[o*P +: P]), 64'(exp));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] ent;
        int         r;
        rstn = 1'b0;
        lut  = 12'b000_100_010_001;
        drv('0, '0, '0, '0, '0, '0);
        model_clear();
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Routing: src0 to DST 2.
        drv(2'b01, 10'h2AA, 10'h000, '0, '0, 3'b000);
        step();
        drv('0, '0, '0, '0, '0, 3'b000);
        #1;
        chk("route_vld_m", 64'(vld_m), 64'(3'b100));
        chk("route_pld_m", 64'(pld_m[2*P +: P]), 64'(10'h2AA));
        step();
        drv('0, '0, '0, '0, '0, 3'b111);
        repeat (2) step();

        // Arbitration: both sources to DST 1 with continuous pop.
        for (int k = 0; k < 6; k++) begin
            drv(2'b11, 10'(10'h100 + k), 10'(10'h180 + k), '0, '0, 3'b010);
            step();
        end
        drv('0, '0, '0, '0, '0, 3'b111);
        repeat (3) step();

        // Back-pressure: three beats into a stalled output, then one pop.
        for (int k = 0; k < 3; k++) begin
            drv(2'b10, 10'h000, 10'(10'h140 + k), '0, '0, 3'b000);
            step();
        end
        #1;
        chk("bp_lvl_full", 64'(lvl_m[1*LW +: LW]), 64'(DEPTH));
        chk("bp_gnt_low", 64'(gnt_s[1]), 64'(0));
        drv(2'b10, 10'h000, 10'h142, '0, '0, 3'b010);
        step();
        drv(2'b10, 10'h000, 10'h142, '0, '0, 3'b000);
        step();

        // Reset mid-stream with a full FIFO and a source still valid.
        drv(2'b11, 10'h111, 10'h122, '0, '0, 3'b000);
        rstn = 1'b0;
        #1;
        chk_reset_state("midrst");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        // Pointer back at src0.
        for (int k = 0; k < 2; k++) begin
            drv(2'b11, 10'(10'h130 + k), 10'(10'h1B0 + k), '0, '0, 3'b010);
            step();
        end

        // Lock: src0 occupies on beat 1 and releases on beat 4.
        for (int k = 1; k <= 6; k++) begin
            drv(2'b11, 10'(10'h160 + k), 10'(10'h1E0 + k), 2'(k == 1), 2'(k == 4), 3'b010);
            step();
        end
        drv('0, '0, '0, '0, '0, 3'b111);
        repeat (3) step();

        // Unmapped DST 3 from src1.
        drv(2'b10, 10'h000, 10'h3C5, '0, '0, 3'b111);
        step();
        drv('0, '0, '0, '0, '0, 3'b111);
        #1;
        chk("unmap_err", 64'(err_s), 64'(2'b10));
        chk("unmap_no_vld", 64'(vld_m), 64'(0));
        step();
        step();

        // Random traffic with occasional table changes while idle.
        for (int c = 0; c < 1500; c++) begin
            if (c % 300 == 299) begin
                drv('0, '0, '0, '0, '0, 3'(($urandom)));
                step();
                for (int d = 0; d < NE; d++) begin
                    r   = int'($urandom_range(0, M));
                    ent = (r == M) ? 3'b000 : 3'(1 << r);
                    lut[d*M +: M] = ent;
                end
            end
            drv(2'($urandom), 10'($urandom), 10'($urandom),
                2'($urandom_range(0, 3) == 0 ? $urandom : 0),
                2'($urandom_range(0, 3) == 0 ? $urandom : 0),
                3'($urandom));
            step();
        end

        // Drain everything.
        drv('0, '0, '0, '0, '0, 3'b111);
        repeat (4) step();
        for (int o = 0; o < M; o++) begin
            chk("drain_sb_empty", 64'(sb_q[o].size()), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xsw_nm_buf.md
# xsw_nm_buf

N-input by M-output crossbar switch with a built-in round-robin arbiter on each output, optional per-output lock (occupy/release), and a DEPTH-entry output FIFO on every output port. Each payload is routed by its DST_ID field through a runtime lookup table. A payload whose table entry is empty is accepted and dropped, and an error is flagged. The block replaces the unbuffered switch in fabric levels where output back-pressure must not stall arbitration.

## Interface
- N, 2: number of source (input) ports, ≥1
- M, 3: number of destination (output) ports, ≥1
- P, 10: payload width in bits; DST_ID occupies pld[P-1 -: LU_N]
- LU_N, 2: DST_ID width; the table has 2**LU_N entries
- DEPTH, 2: entries per output FIFO, ≥1, need not be a power of two
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- lut  in  (2**LU_N)*M  quasi-static table; lut[d*M +: M] is the one-hot target for DST_ID d, and all-zero means unmapped
- vld_s  in  N  source valid
- pld_s  in  N*P  source payloads, lane i at [i*P +: P]
- gnt_s  out  N  source grant; the transfer occurs when vld_s[i] & gnt_s[i]; combinational
- ocy  in  N  source i requests a lock starting with this beat
- rel  in  N  source i releases its lock after this beat
- vld_m  out  M  output valid (FIFO not empty)
- pld_m  out  M*P  FIFO head payloads
- gnt_m  in  M  output pop; the pop occurs when vld_m[o] & gnt_m[o]
- err_s  out  N  one-cycle pulse: source i had an unmapped beat accepted
- lvl_m  out  M*$clog2(DEPTH+1)  per-output FIFO occupancy

## Operation
- Target: tgt[i] = lut[DST_ID(pld_s[i])*M +: M]. A target with more than one bit set is illegal; an assertion fires when vld_s is high.
- Unmapped beat (tgt == 0):
  - gnt_s[i] = 1 in the same cycle.
  - The payload is discarded.
  - err_s[i] = 1 in the next cycle.
- Request matrix: req[o][i] = vld_s[i] & tgt[i][o] & lock_ok[o][i].
- Output o may grant only when lvl_m[o] < DEPTH. Push and pop are never combined to free a slot: a full FIFO refuses the push even in a pop cycle.
- Arbitration per output is round-robin with a pointer ptr[o]:
  - The first requester at or after ptr[o], wrapping, wins.
  - After a grant to source i, ptr[o] = (i+1) mod N.
  - ptr[o] holds when there is no grant.
- At most one gnt_s bit per output per cycle. Each source targets one output, so each gnt_s bit depends on a single output.
- Push: the granted payload is written at wptr[o], and wptr wraps from DEPTH-1 to 0.
- Pop: rptr[o] advances, with the same wrap rule.
- Simultaneous push and pop on a non-full FIFO: lvl is unchanged.
- Empty FIFO: vld_m[o] = 0 and pld_m lane = 0 (masked).

## Timing
- Reset values: vld_m = 0, pld_m = 0, lvl_m = 0, err_s = 0, all ptr = 0, all locks clear.
- gnt_s is forced to 0 while rstn is low.
- Reset asserted mid-operation flushes all FIFOs and locks immediately (asynchronous).
- Latency: a beat accepted at edge k appears as vld_m = 1 in the cycle after edge k (1 cycle), provided the FIFO was empty.
- Throughput: 1 beat per output per cycle.
- gnt_s depends combinationally on vld_s, pld_s, lut, ocy and state. It never depends on gnt_m.
- A change to lut is allowed only while all vld_s are low. The result is undefined otherwise.

## Configuration
- XSW_LOCK_EN defined:
  - Each output has state FREE or LOCKED(owner).
  - FREE → LOCKED(i) on a grant to i with ocy[i] & ~rel[i].
  - LOCKED(i) → FREE on a grant to i with rel[i].
  - While LOCKED(i), lock_ok[o][j] = (j == i). The lock holds across cycles when vld_s[i] is low.
  - ocy & rel on the same beat is a single-beat transfer with no lock.
- XSW_LOCK_EN undefined:
  - ocy and rel are ignored.
  - lock_ok is always 1 and arbitration is round-robin per beat.

## Structure
- Package xsw_pkg holds:
  - the lock-state enum (FREE/LOCKED)
  - the function rr_pick(req, ptr), returning the one-hot winner
  - a localparam helper for the lvl width
- Sub-module xsw_ofifo #(P, DEPTH) holds the storage, wptr, rptr and lvl. It is instantiated M times.

## Test plan
- Routing (N=2, M=3, lut = d0→001, d1→010, d2→100): src0 sends DST 2, pld 0x2AA. Expect gnt_s = 01 in the same cycle, vld_m = 100 in the next cycle, pld_m lane 2 = 0x2AA.
- Arbitration: both sources drive DST 1 continuously, gnt_m = 1. Grants alternate 01, 10, 01, … starting with src0 after reset.
- Back-pressure (DEPTH=2): gnt_m[1] = 0 and 3 beats are offered. Expect 2 accepted, lvl = 2, gnt_s low on the third. One pop frees one slot, and the third beat is accepted the following cycle.
- Lock (XSW_LOCK_EN): src0 asserts ocy on beat 1 and rel on beat 4, while src1 requests throughout. Expect src1 starved for beats 1–4 and granted on the next cycle. Without the macro, the grants alternate.
- Unmapped: lut entry 3 = 0 and src1 sends DST 3. Expect gnt_s[1] = 1, no vld_m, err_s[1] pulse for one cycle.
- Reset mid-stream with lvl = 2: drop rstn. Expect vld_m = 0, lvl_m = 0, gnt_s = 0 immediately, and ptr back to 0 after release.
